// File: rtl/inst_fetch_queue_if.sv
// Instruction-memory request/acknowledge channel used by the fetch queue.
// The master issues word-aligned requests; the slave completes them with ack and rdata.
interface inst_fetch_queue_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/inst_fetch_queue.sv
// IF-stage prefetch queue: fetches sequential words from a handshaked memory ahead of decode,
// holds them through decode stalls and flushes/refetches on a branch or jump redirect.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      redirect,
  input  logic [31:0]               redirect_pc,
  inst_fetch_queue_if.master        imem,
  output logic                      inst_valid,
  output logic [31:0]               inst,
  output logic [31:0]               pc_plus4
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_plus4;
  } entry_t;

  state_t           state, state_n;
  logic [31:0]      fetch_pc, fetch_pc_n;
  logic [31:0]      addr_q, addr_n;
  logic [31:0]      pc_next;
  logic [31:0]      target;
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, count_after_push;
  logic             push, pop, flush;
  logic             unused_pc_bits;

  assign target         = {redirect_pc[31:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc[1:0];
  assign pc_next        = fetch_pc + 32'd4;

  assign inst_valid       = (count != '0);
  assign pop              = inst_valid & ~stall & ~redirect;
  assign count_after_push = pop ? count : count + CNT_W'(1);

  assign imem.req  = (state != IDLE);
  assign imem.addr = addr_q;

  // Head entry drives decode; NOP and zero PC whenever the queue is empty.
  assign inst     = inst_valid ? mem[rd_ptr].inst     : 32'h0;
  assign pc_plus4 = inst_valid ? mem[rd_ptr].pc_plus4 : 32'h0;

  // Fetch control: redirect beats ack, ack beats pop; addr only moves when a new request starts.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    addr_n     = addr_q;
    push       = 1'b0;
    flush      = 1'b0;
    unique case (state)
      IDLE: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_n = target;
          addr_n     = target;
          state_n    = REQ;
        end else if (count < CNT_W'(DEPTH)) begin
          addr_n  = fetch_pc;
          state_n = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_n = target;
          if (imem.ack) addr_n = target;
          else          state_n = DROP;
        end else if (imem.ack) begin
          push       = 1'b1;
          fetch_pc_n = pc_next;
          if (count_after_push < CNT_W'(DEPTH)) addr_n = pc_next;
          else                                  state_n = IDLE;
        end
      end
      DROP: begin
        // A redirect landing on the squashed request's ack restarts at once at the new target.
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_n = target;
          if (imem.ack) begin
            addr_n  = target;
            state_n = REQ;
          end
        end else if (imem.ack) begin
          addr_n  = fetch_pc;
          state_n = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      addr_q   <= addr_n;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{inst: imem.rdata, pc_plus4: pc_next};
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: a memory responder, a sequential-stream scoreboard fed on each
// restart (reset/redirect), and a monitor that checks every word decode consumes.
module tb_inst_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic [31:0] inst, pc_plus4;

  inst_fetch_queue_if imem ();

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem(imem), .inst_valid(inst_valid), .inst(inst), .pc_plus4(pc_plus4)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          pop_cnt = 0;
  int unsigned lat_mode = 0;   // 0..3 fixed wait states, 4 = random per request
  bit          spur_en = 1'b0; // random ack pulses while no request is outstanding

  // Reference: decode must see an unbroken sequential stream starting at the last restart PC.
  logic [31:0] exp_q[$];
  logic [31:0] fill_pc;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hA500_0000;
  endfunction

  function automatic void model_fill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(fill_pc);
      fill_pc = fill_pc + 32'd4;
    end
  endfunction

  function automatic void model_restart(input logic [31:0] pc);
    exp_q.delete();
    fill_pc = {pc[31:2], 2'b00};
    model_fill();
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory: ack after cur_lat wait states, data is a fixed function of the address.
  initial begin
    int unsigned wcnt = 0;
    int unsigned cur_lat = 0;
    bit          last_done = 1'b0;
    imem.ack   = 1'b0;
    imem.rdata = 32'h0;
    forever begin
      @(negedge clk); #1;
      if (!rst || !imem.req || last_done) begin
        wcnt    = 0;
        cur_lat = (lat_mode > 3) ? $urandom_range(0, 3) : lat_mode;
      end
      if (rst && imem.req) begin
        imem.ack = (wcnt >= cur_lat);
        if (!imem.ack) wcnt++;
        imem.rdata = imem.ack ? word_at(imem.addr) : 32'hDEAD_BEEF;
      end else begin
        imem.ack   = spur_en ? ($urandom_range(0, 1) == 1) : 1'b0;
        imem.rdata = $urandom;
      end
      last_done = rst && imem.req && imem.ack;
    end
  end

  // Monitor, sampled 1 time unit before each rising edge.
  initial begin
    bit          prev_wait = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] prev_inst = 32'h0;
    logic [31:0] prev_p4   = 32'h0;
    logic [31:0] e;
    forever begin
      @(negedge clk); #4;
      if (!rst) begin
        prev_wait = 1'b0;
        prev_hold = 1'b0;
        continue;
      end
      if (prev_wait) begin
        chk("hs_req_held", 32'(imem.req), 32'd1);
        chk("hs_addr_stable", imem.addr, prev_addr);
      end
      if (prev_hold) begin
        chk("stall_inst_held", inst, prev_inst);
        chk("stall_pc4_held", pc_plus4, prev_p4);
      end
      if (imem.req) chk("addr_align", 32'(imem.addr[1:0]), 32'd0);
      if (!inst_valid) begin
        chk("empty_inst", inst, 32'h0);
        chk("empty_pc4", pc_plus4, 32'h0);
      end else if (!stall && !redirect) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_underflow: got %08h, expected no word at t=%0t", inst, $time);
        end else begin
          n_cmp--;
          e = exp_q.pop_front();
          chk("stream_inst", inst, word_at(e));
          chk("stream_pc4", pc_plus4, e + 32'd4);
          pop_cnt++;
          model_fill();
        end
      end
      prev_wait = imem.req && !imem.ack;
      prev_addr = imem.addr;
      prev_hold = inst_valid && stall && !redirect;
      prev_inst = inst;
      prev_p4   = pc_plus4;
    end
  end

  // Fill the queue under stall with zero-wait memory; the fetcher must then go idle.
  task automatic settle_full();
    stall    = 1'b1;
    redirect = 1'b0;
    lat_mode = 0;
    spur_en  = 1'b0;
    repeat (12) @(negedge clk);
    #3;
    chk("full_req_low", 32'(imem.req), 32'd0);
    chk("full_valid", 32'(inst_valid), 32'd1);
  endtask

  initial begin
    logic [31:0] h;
    logic [31:0] t;
    int          p0;

    // Reset values and first-fetch latency with zero-wait memory
    model_restart(RESET_PC);
    repeat (3) @(negedge clk);
    #3;
    chk("rst_req", 32'(imem.req), 32'd0);
    chk("rst_addr", imem.addr, RESET_PC);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h0);
    @(negedge clk); rst = 1'b1; #3;
    chk("rel_req0", 32'(imem.req), 32'd0);
    @(negedge clk); #3;
    chk("rel_req1", 32'(imem.req), 32'd1);
    chk("rel_addr0", imem.addr, RESET_PC);
    chk("rel_valid0", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #3;
      chk("seq_valid", 32'(inst_valid), 32'd1);
      chk("seq_inst", inst, word_at(RESET_PC + 32'(4 * i)));
      chk("seq_pc4", pc_plus4, RESET_PC + 32'(4 * i + 4));
    end

    // Three wait states per request
    lat_mode = 3;
    repeat (40) @(negedge clk);

    // Decode stall: queue fills, output held, then drains and refills
    settle_full();
    h = inst;
    repeat (3) @(negedge clk);
    #3;
    chk("stall_hold", inst, h);
    @(negedge clk); stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #3;
      if (imem.req) break;
    end
    chk("refill_req", 32'(imem.req), 32'd1);
    repeat (10) @(negedge clk);

    // Redirect while a request is waiting: squash it, then fetch the new target
    settle_full();
    @(negedge clk);
    lat_mode = 3; redirect = 1'b1; redirect_pc = 32'h10; model_restart(32'h10);
    @(negedge clk);
    redirect_pc = 32'h40; stall = 1'b0; model_restart(32'h40);
    #3;
    chk("drop_req", 32'(imem.req), 32'd1);
    chk("drop_addr_pending", imem.addr, 32'h10);
    @(negedge clk); redirect = 1'b0; #3;
    chk("drop_addr_held", imem.addr, 32'h10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #3;
      if (imem.addr != 32'h10) break;
    end
    chk("drop_next_addr", imem.addr, 32'h40);
    chk("drop_next_req", 32'(imem.req), 32'd1);
    repeat (20) @(negedge clk);

    // Redirect on the ack edge: no push, unaligned target forced to word boundary
    settle_full();
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h100; model_restart(32'h100);
    @(negedge clk);
    redirect_pc = 32'h83; model_restart(32'h80);
    @(negedge clk);
    redirect = 1'b0; stall = 1'b0; #3;
    chk("redir_ack_addr", imem.addr, 32'h80);
    chk("redir_ack_req", 32'(imem.req), 32'd1);
    chk("redir_ack_nopush", 32'(inst_valid), 32'd0);
    @(negedge clk); #3;
    chk("redir_ack_first", inst, word_at(32'h80));
    repeat (8) @(negedge clk);

    // Address wrap across 2^32
    settle_full();
    @(negedge clk);
    stall = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; model_restart(32'hFFFF_FFF8);
    @(negedge clk); redirect = 1'b0;
    @(negedge clk); #3;
    chk("wrap_pc4_a", pc_plus4, 32'hFFFF_FFFC);
    @(negedge clk); #3;
    chk("wrap_pc4_b", pc_plus4, 32'h0);
    @(negedge clk); #3;
    chk("wrap_inst_c", inst, word_at(32'h0));
    repeat (5) @(negedge clk);

    // Asynchronous reset with two words queued and a request waiting
    settle_full();
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h200; model_restart(32'h200);
    @(negedge clk); redirect = 1'b0;
    @(negedge clk);
    @(negedge clk);
    lat_mode = 3;
    #2;
    chk("pre_rst_valid", 32'(inst_valid), 32'd1);
    chk("pre_rst_inst", inst, word_at(32'h200));
    chk("pre_rst_addr", imem.addr, 32'h208);
    rst = 1'b0;
    model_restart(RESET_PC);
    #1;
    chk("arst_valid", 32'(inst_valid), 32'd0);
    chk("arst_inst", inst, 32'h0);
    chk("arst_pc4", pc_plus4, 32'h0);
    chk("arst_req", 32'(imem.req), 32'd0);
    chk("arst_addr", imem.addr, RESET_PC);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; lat_mode = 0; stall = 1'b0; #3;
    chk("rerel_req0", 32'(imem.req), 32'd0);
    @(negedge clk); #3;
    chk("rerel_req1", 32'(imem.req), 32'd1);
    chk("rerel_addr", imem.addr, RESET_PC);
    repeat (6) @(negedge clk);

    // Randomized traffic: random stalls, redirects, latencies and stray acks
    lat_mode = 4;
    spur_en  = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) begin
        t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                        : ($urandom & 32'h0000_0FFF);
        redirect    = 1'b1;
        redirect_pc = t;
        model_restart(t);
      end else begin
        redirect = 1'b0;
      end
    end

    // Zero-wait steady state must deliver close to one word per cycle
    @(negedge clk);
    stall = 1'b0; redirect = 1'b0; lat_mode = 0; spur_en = 1'b0;
    repeat (5) @(negedge clk);
    p0 = pop_cnt;
    repeat (30) @(negedge clk);
    #3;
    chk("throughput", 32'((pop_cnt - p0) >= 28), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_cmp++;
    n_fail++;
    $display("FAIL timeout: got no finish, expected finish before t=400000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
